// File: rtl/memory2.sv
// memory2: single-port valid/ready memory with byte enables, wait states and a range-error flag.
// Define MEMORY2_INIT_EN to zero-fill the array after reset before the first request is accepted.
module memory2 #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int BE_WIDTH    = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [WIDTH-1:0]      rdata,
    output logic                  done,
    output logic                  err
);
`ifdef MEMORY2_INIT_EN
    typedef enum logic [1:0] {IDLE, BUSY, INIT} state_t;
    logic [ADDR_WIDTH-1:0] init_cnt;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] h_addr, op_addr;
    logic [WIDTH-1:0]      h_wdata, op_wdata;
    logic [BE_WIDTH-1:0]   h_be, op_be;
    logic                  h_wr, op_wr;
    logic                  exec, in_range;
    // With no wait states the operation runs straight off the bus at the accept edge.
    always_comb begin
        op_addr  = (WAIT_STATES == 0) ? addr  : h_addr;
        op_wdata = (WAIT_STATES == 0) ? wdata : h_wdata;
        op_be    = (WAIT_STATES == 0) ? be    : h_be;
        op_wr    = (WAIT_STATES == 0) ? wr_rd : h_wr;
        in_range = {1'b0, op_addr} < DEPTH_W;
        exec     = rst && ((WAIT_STATES == 0) ? (state == IDLE && valid)
                                              : (state == BUSY && cnt == 4'd0));
    end
    always_ff @(posedge clk) begin
`ifdef MEMORY2_INIT_EN
        if (rst && state == INIT)
            mem[init_cnt] <= '0;
`endif
        if (exec && op_wr && in_range)
            for (int i = 0; i < BE_WIDTH; i++)
                if (op_be[i])
                    mem[op_addr][8*i +: 8] <= op_wdata[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef MEMORY2_INIT_EN
            state    <= INIT;
            ready    <= 1'b0;
            init_cnt <= '0;
`else
            state    <= IDLE;
            ready    <= 1'b1;
`endif
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            h_addr   <= '0;
            h_wdata  <= '0;
            h_be     <= '0;
            h_wr     <= 1'b0;
        end else begin
            done <= exec;
            err  <= exec && !in_range;
            if (exec && !op_wr)
                rdata <= in_range ? mem[op_addr] : '0;
            case (state)
                IDLE: if (valid) begin
                    h_addr  <= addr;
                    h_wdata <= wdata;
                    h_be    <= be;
                    h_wr    <= wr_rd;
                    if (WAIT_STATES != 0) begin
                        state <= BUSY;
                        ready <= 1'b0;
                        cnt   <= 4'(WAIT_STATES - 1);
                    end
                end
                BUSY: if (cnt == 4'd0) begin
                    state <= IDLE;
                    ready <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
`ifdef MEMORY2_INIT_EN
                INIT: if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state <= IDLE;
                    ready <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory2.sv
// tb_memory2: random and directed transfers on a zero-wait 16-word memory and a 3-wait 12-word memory,
// checked against an array model of per-byte writes, latency and out-of-range behaviour.
module tb_memory2;
    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  valid, wr_rd, ready, done, err;
    logic [3:0]  addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];
    logic [1:0]  be    [2];
    logic [15:0] mdl   [2][16];
    logic [15:0] last_rd [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    memory2 #(.DEPTH(16), .WIDTH(16), .WAIT_STATES(0)) dut (
        .clk(clk), .rst(rst[0]), .valid(valid[0]), .ready(ready[0]), .wr_rd(wr_rd[0]),
        .addr(addr[0]), .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .done(done[0]), .err(err[0])
    );
    memory2 #(.DEPTH(12), .WIDTH(16), .WAIT_STATES(3)) dut_ws (
        .clk(clk), .rst(rst[1]), .valid(valid[1]), .ready(ready[1]), .wr_rd(wr_rd[1]),
        .addr(addr[1]), .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .done(done[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [3:0] a, input logic [15:0] d,
                        input logic [1:0] b);
        int dep = (k == 1) ? 12 : 16;
        int ws  = (k == 1) ? 3 : 0;
        int lat = 0;
        int busy = 0;
        logic exp_err = int'(a) >= dep;
        for (int t = 0; t < 50 && !ready[k]; t++) begin
            @(posedge clk); #1;
        end
        check("ready_idle", 32'(ready[k]), 32'd1);
        valid[k] = 1'b1; wr_rd[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        @(posedge clk); #1;
        valid[k] = 1'b0; wr_rd[k] = 1'($urandom); addr[k] = 4'($urandom);
        wdata[k] = 16'($urandom); be[k] = 2'($urandom);
        while (!done[k] && lat < 50) begin
            if (!ready[k]) busy++;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, ws);
        check("busy_cycles", busy, ws);
        check("ready_at_done", 32'(ready[k]), 32'd1);
        if (!w) last_rd[k] = exp_err ? 16'h0 : mdl[k][a];
        else if (!exp_err)
            for (int i = 0; i < 2; i++)
                if (b[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
        check(w ? "rdata_hold" : "rdata", 32'(rdata[k]), 32'(last_rd[k]));
        check("err", 32'(err[k]), 32'(exp_err));
        @(posedge clk); #1;
        check("done_pulse", 32'(done[k]), 32'd0);
        check("err_pulse", 32'(err[k]), 32'd0);
    endtask

    initial begin
        rst = 2'b00; valid = 2'b00; wr_rd = 2'b00;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; wdata[k] = '0; be[k] = '0; last_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
`ifndef MEMORY2_INIT_EN
            check("rst_ready", 32'(ready[k]), 32'd1);
`endif
            check("rst_done", 32'(done[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_rdata", 32'(rdata[k]), 32'd0);
        end
        rst = 2'b11;

        for (int a = 0; a < 16; a++) xfer(0, 1'b1, 4'(a), 16'($urandom), 2'b11);
        for (int a = 0; a < 16; a++) xfer(0, 1'b0, 4'(a), 16'h0, 2'b00);
        for (int n = 0; n < 60; n++)
            xfer(0, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom));

        for (int a = 0; a < 12; a++) xfer(1, 1'b1, 4'(a), 16'($urandom), 2'b11);
        xfer(1, 1'b1, 4'd5, 16'hA5A5, 2'b11);
        xfer(1, 1'b0, 4'd5, 16'h0, 2'b00);
        check("ws_a5a5", 32'(rdata[1]), 32'h0000A5A5);
        xfer(1, 1'b1, 4'd3, 16'hFFFF, 2'b11);
        xfer(1, 1'b1, 4'd3, 16'h1234, 2'b01);
        xfer(1, 1'b0, 4'd3, 16'h0, 2'b00);
        check("be_merge", 32'(rdata[1]), 32'h0000FF34);
        xfer(1, 1'b1, 4'd3, 16'h0000, 2'b00);
        xfer(1, 1'b0, 4'd3, 16'h0, 2'b00);
        check("be_none", 32'(rdata[1]), 32'h0000FF34);
        xfer(1, 1'b1, 4'd13, 16'hBEEF, 2'b11);
        xfer(1, 1'b0, 4'd13, 16'h0, 2'b00);
        for (int a = 0; a < 12; a++) check("backdoor", 32'(dut_ws.mem[a]), 32'(mdl[1][a]));
        for (int n = 0; n < 30; n++)
            xfer(1, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom));

        xfer(1, 1'b1, 4'd7, 16'h0000, 2'b11);
        valid[1] = 1'b1; wr_rd[1] = 1'b1; addr[1] = 4'd7; wdata[1] = 16'h5555; be[1] = 2'b11;
        @(posedge clk); #1;
        valid[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        #1;
        check("abort_ready", 32'(ready[1]), 32'd1);
        check("abort_done", 32'(done[1]), 32'd0);
        check("abort_rdata", 32'(rdata[1]), 32'd0);
        last_rd[1] = 16'h0;
        #2 rst[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 4'd7, 16'h0, 2'b00);
        check("abort_mem", 32'(rdata[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
